// File: rtl/zeroheti_rst_seq.sv
// rtl/zeroheti_rst_seq.sv - staggered SoC reset sequencer with lock/button synchronisers and reset-cause record
// Optional button debounce enabled by defining ZH_RST_BTN_DEBOUNCE_EN; otherwise a press is the synchronised rising edge.
module zeroheti_rst_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int STRETCH_CYCLES  = 16,
    parameter int STAGGER_CYCLES  = 4,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       btn_i,
    output logic       periph_rst_no,
    output logic       core_rst_no,
    output logic       ready_o,
    output logic [1:0] cause_o
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] CAUSE_RST  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;

    if (SYNC_STAGES < 2 || STRETCH_CYCLES < 1 || STAGGER_CYCLES < 1 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("zeroheti_rst_seq: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STRETCH   = 2'd1,
        S_PERIPH    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic                   w_locked_s;
    logic                   w_btn_s;
    logic                   w_press;
    logic                   w_active;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [1:0]             r_cause;
    logic                   r_periph_rst_n;
    logic                   r_core_rst_n;
    logic                   r_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked_i};
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
    assign w_btn_s    = r_btn_sync[SYNC_STAGES-1];

`ifdef ZH_RST_BTN_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DBW-1:0] r_db_cnt;

    // Saturates at DEBOUNCE_CYCLES so a held button fires only once until released.
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_btn_s) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt != DBW'(DEBOUNCE_CYCLES)) begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_press = w_btn_s && (r_db_cnt == DBW'(DEBOUNCE_CYCLES - 1));
`else
    logic r_btn_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= w_btn_s;
        end
    end

    assign w_press = w_btn_s && !r_btn_q;
`endif

    assign w_active = (r_state != S_WAIT_LOCK);

    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= S_WAIT_LOCK;
            r_cnt          <= '0;
            r_cause        <= CAUSE_RST;
            r_periph_rst_n <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_ready        <= 1'b0;
        end else if (w_active && !w_locked_s) begin
            r_state        <= S_WAIT_LOCK;
            r_cnt          <= '0;
            r_cause        <= CAUSE_LOCK;
            r_periph_rst_n <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_ready        <= 1'b0;
        end else if (w_active && w_press) begin
            r_state        <= S_WAIT_LOCK;
            r_cnt          <= '0;
            r_cause        <= CAUSE_BTN;
            r_periph_rst_n <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_ready        <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_state <= S_STRETCH;
                        r_cnt   <= '0;
                    end
                end
                S_STRETCH: begin
                    if (r_cnt == CW'(STRETCH_CYCLES - 1)) begin
                        r_state        <= S_PERIPH;
                        r_cnt          <= '0;
                        r_periph_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PERIPH: begin
                    if (r_cnt == CW'(STAGGER_CYCLES - 1)) begin
                        r_state      <= S_RUN;
                        r_cnt        <= '0;
                        r_core_rst_n <= 1'b1;
                        r_ready      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state        <= S_WAIT_LOCK;
                    r_cnt          <= '0;
                    r_periph_rst_n <= 1'b0;
                    r_core_rst_n   <= 1'b0;
                    r_ready        <= 1'b0;
                end
            endcase
        end
    end

    assign periph_rst_no = r_periph_rst_n;
    assign core_rst_no   = r_core_rst_n;
    assign ready_o       = r_ready;
    assign cause_o       = r_cause;

endmodule
